syncram_dp: RTL and testbench
=============================

SYNCRAM_DP -- requirements
Module: syncram_dp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width for both ports.
REQ-002 SHALL have parameter WIDTHAD, default 8, address width; depth = 2**WIDTHAD.
REQ-003 SHALL have parameter BYTE_SIZE, default 8, byte-enable granularity; WIDTH % BYTE_SIZE == 0, else elaboration error.
REQ-004 SHALL have parameter OUTDATA_REG, default 0; 1 adds an output register stage.
REQ-005 SHALL have parameter RDW_MODE, default "OLD_DATA"; alternative "NEW_DATA"; governs same-port read-during-write.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1; 1 zero-fills memory after reset.
REQ-007 SHALL have port clock0, in, 1, sole clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port sclr, in, 1, synchronous active-high reset.
REQ-009 SHALL have port clocken0, in, 1, global clock enable.
REQ-010 SHALL have ports wren_a/wren_b, in, 1, write requests.
REQ-011 SHALL have ports rden_a/rden_b, in, 1, read requests.
REQ-012 SHALL have ports address_a/address_b, in, WIDTHAD, word addresses.
REQ-013 SHALL have ports addressstall_a/addressstall_b, in, 1, hold the previously latched address.
REQ-014 SHALL have ports data_a/data_b, in, WIDTH, write data.
REQ-015 SHALL have ports byteena_a/byteena_b, in, WIDTH/BYTE_SIZE, per-byte write enables.
REQ-016 SHALL have ports q_a/q_b, out, WIDTH, read data.
REQ-017 SHALL have port init_busy, out, 1, high while the zero-fill sweep runs.
REQ-018 SHALL have port collision, out, 1, one-cycle pulse on a same-address dual write.

Function
REQ-019 Each port SHALL latch its address on every enabled edge unless addressstall_x=1, which keeps the last latched address for both read and write.
REQ-020 A write SHALL update only bytes whose byteena bit is 1; all-zero byteena writes nothing.
REQ-021 Read latency SHALL be 1 cycle (OUTDATA_REG=0) or 2 cycles (OUTDATA_REG=1) from rden edge to q.
REQ-022 With rden_x=0, q_x SHALL hold its previous value.
REQ-023 Same-port read and write to one address: "OLD_DATA" returns pre-write word; "NEW_DATA" returns the byte-merged new word.
REQ-024 Cross-port read of an address the other port writes in the same cycle SHALL return the old word regardless of RDW_MODE.
REQ-025 Both ports writing the same address in the same cycle: port A bytes win wherever byteena_a=1; port B bytes land elsewhere; collision=1 for that cycle.
REQ-026 clocken0=0 SHALL freeze everything: no write, no address latch, q, sweep counter and FSM state held; collision=0.
REQ-027 Control FSM states: CLEAR, READY.
REQ-028 From reset: CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-029 CLEAR SHALL write zero to address counter 0,1,...,2**WIDTHAD-1, one word per enabled cycle, then go to READY.
REQ-030 In CLEAR, wren/rden on both ports SHALL be ignored, q_a/q_b=0, init_busy=1.
REQ-031 init_busy SHALL be 0 from the first READY cycle.

Reset
REQ-032 While sclr=1 the block SHALL drive q_a=q_b=0, collision=0, zero latched addresses and output registers, clear the sweep counter, and set init_busy=CLEAR_ON_RESET.
REQ-033 sclr SHALL override clocken0.
REQ-034 sclr during CLEAR SHALL restart the sweep from address 0.
REQ-035 sclr SHALL NOT alter memory contents when CLEAR_ON_RESET=0.

Structure
REQ-036 Package syncram_pkg SHALL hold the FSM state enum, the RDW mode constants and a function returning WIDTH/BYTE_SIZE.
REQ-037 Sub-module syncram_clear_fsm SHALL own the state register, sweep counter and init_busy; the memory array and port logic stay in syncram_dp.

Verification
REQ-038 WIDTHAD=4, CLEAR_ON_RESET=1, sclr 1 cycle -> init_busy high exactly 16 cycles; every address then reads 0x00000000.
REQ-039 Port A writes 0xAABBCCDD to addr 3, then byteena_a=4'b0101 data 0x11223344 -> read addr 3 returns 0xAA22CC44 after 1 cycle (2 with OUTDATA_REG=1).
REQ-040 Addr 5 = 0x1; port A write 0x2 + read addr 5 same cycle -> q_a=0x1 ("OLD_DATA"), 0x2 ("NEW_DATA"); port B reading addr 5 that cycle -> 0x1 in both modes.
REQ-041 Both ports write addr 7, A=0xFFFF0000 byteena 4'b1100, B=0x0000FFFF byteena 4'b1111 -> collision=1 one cycle; addr 7 = 0xFFFFFFFF.
REQ-042 addressstall_a=1 while address_a changes 2->9, rden_a=1 -> q_a keeps returning addr 2 word; clocken0=0 mid-CLEAR -> sweep counter and init_busy hold, resume on re-enable.

Source files
------------

// File: rtl/syncram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : syncram_pkg
//  Description : Shared types and constants for the dual-port synchronous RAM
//                (control FSM states, read-during-write modes, byte helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package syncram_pkg;

    // Control FSM: zero-fill sweep, then normal operation
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Same-port read-during-write behaviour selectors
    localparam RDW_OLD_DATA = "OLD_DATA";
    localparam RDW_NEW_DATA = "NEW_DATA";

    // Number of byte lanes in one data word
    function automatic int bytes_per_word(input int width, input int byte_size);
        return width / byte_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/syncram_dp_if.sv
`default_nettype none
// ============================================================================
//  Module      : syncram_dp_if
//  Description : Port A / port B bus of the dual-port RAM plus status outputs.
//                master = requester side, slave = RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface syncram_dp_if
    import syncram_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int WIDTHAD   = 8,
    parameter int BYTE_SIZE = 8
);
    localparam int NBYTES = bytes_per_word(WIDTH, BYTE_SIZE);

    logic               wren_a;
    logic               wren_b;
    logic               rden_a;
    logic               rden_b;
    logic [WIDTHAD-1:0] address_a;
    logic [WIDTHAD-1:0] address_b;
    logic               addressstall_a;
    logic               addressstall_b;
    logic [WIDTH-1:0]   data_a;
    logic [WIDTH-1:0]   data_b;
    logic [NBYTES-1:0]  byteena_a;
    logic [NBYTES-1:0]  byteena_b;
    logic [WIDTH-1:0]   q_a;
    logic [WIDTH-1:0]   q_b;
    logic               init_busy;
    logic               collision;

    modport master (
        output wren_a, wren_b, rden_a, rden_b,
        output address_a, address_b, addressstall_a, addressstall_b,
        output data_a, data_b, byteena_a, byteena_b,
        input  q_a, q_b, init_busy, collision
    );

    modport slave (
        input  wren_a, wren_b, rden_a, rden_b,
        input  address_a, address_b, addressstall_a, addressstall_b,
        input  data_a, data_b, byteena_a, byteena_b,
        output q_a, q_b, init_busy, collision
    );

endinterface
`default_nettype wire

// File: rtl/syncram_clear_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : syncram_clear_fsm
//  Description : Control FSM for the dual-port RAM. Owns the zero-fill sweep
//                counter and the init_busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module syncram_clear_fsm
    import syncram_pkg::*;
#(
    parameter int WIDTHAD        = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               en,
    output logic                    busy,
    output logic                    clear_we,
    output logic [WIDTHAD-1:0]      clear_addr
);

    localparam state_t             RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    localparam logic [WIDTHAD-1:0] LAST_ADDR   = '1;

    state_t             state;
    state_t             state_next;
    logic [WIDTHAD-1:0] sweep_cnt;
    logic [WIDTHAD-1:0] sweep_cnt_next;

    // State and sweep counter advance only on enabled edges; reset restarts the sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_STATE;
            sweep_cnt <= '0;
        end else if (en) begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
        end
    end

    // Next-state logic: walk every address once, then settle in READY
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        clear_we       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clear_we       = en && !rst;
                sweep_cnt_next = sweep_cnt + 1'b1;
                if (sweep_cnt == LAST_ADDR) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    // While reset is held the busy flag reflects what the block will do next
    assign busy       = rst ? CLEAR_ON_RESET : (state == ST_CLEAR);
    assign clear_addr = sweep_cnt;

endmodule
`default_nettype wire

// File: rtl/syncram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : syncram_dp
//  Description : True dual-port synchronous RAM, single clock, byte enables,
//                address stall, optional output register, selectable
//                same-port read-during-write, optional zero-fill after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module syncram_dp
    import syncram_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int WIDTHAD        = 8,
    parameter int BYTE_SIZE      = 8,
    parameter bit OUTDATA_REG    = 1'b0,
    parameter     RDW_MODE       = RDW_OLD_DATA,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic     clock0,
    input  wire logic     sclr,
    input  wire logic     clocken0,
    syncram_dp_if.slave   bus
);

    localparam int NBYTES        = bytes_per_word(WIDTH, BYTE_SIZE);
    localparam int DEPTH         = 2 ** WIDTHAD;
    localparam bit NEW_DATA_MODE = (RDW_MODE == RDW_NEW_DATA);

    generate
        if (WIDTH % BYTE_SIZE != 0) begin : g_bad_byte_size
            $error("syncram_dp: WIDTH must be a multiple of BYTE_SIZE");
        end
    endgenerate

    // Replace the lanes selected by be with the matching lanes of new_word
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0]  old_word,
        input logic [WIDTH-1:0]  new_word,
        input logic [NBYTES-1:0] be
    );
        logic [WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                result[i*BYTE_SIZE +: BYTE_SIZE] = new_word[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
        return result;
    endfunction

    logic [WIDTH-1:0]   mem [DEPTH];

    logic               busy;
    logic               clear_we;
    logic [WIDTHAD-1:0] clear_addr;

    logic [WIDTHAD-1:0] addr_a_q;
    logic [WIDTHAD-1:0] addr_b_q;
    logic [WIDTHAD-1:0] addr_a;
    logic [WIDTHAD-1:0] addr_b;
    logic               active;
    logic               we_a;
    logic               we_b;
    logic               same_addr_write;
    logic [WIDTH-1:0]   own_new_a;
    logic [WIDTH-1:0]   own_new_b;
    logic [WIDTH-1:0]   wword_a;
    logic [WIDTH-1:0]   wword_b;
    logic [WIDTH-1:0]   q_core_a;
    logic [WIDTH-1:0]   q_core_b;
    logic [WIDTH-1:0]   q_pipe_a;
    logic [WIDTH-1:0]   q_pipe_b;
    logic               collision_q;

    syncram_clear_fsm #(
        .WIDTHAD        (WIDTHAD),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk        (clock0),
        .rst        (sclr),
        .en         (clocken0),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // A stalled port keeps operating on the address it latched last
    assign addr_a = bus.addressstall_a ? addr_a_q : bus.address_a;
    assign addr_b = bus.addressstall_b ? addr_b_q : bus.address_b;

    assign active          = clocken0 && !sclr && !busy;
    assign we_a            = active && bus.wren_a;
    assign we_b            = active && bus.wren_b;
    assign same_addr_write = we_a && we_b && (addr_a == addr_b);

    // Each port's own view of its write, used for NEW_DATA read-back
    assign own_new_a = byte_merge(mem[addr_a], bus.data_a, bus.byteena_a);
    assign own_new_b = byte_merge(mem[addr_b], bus.data_b, bus.byteena_b);

    // On a same-address dual write, A's lanes are laid over B's merged word
    assign wword_b = own_new_b;
    assign wword_a = byte_merge(same_addr_write ? wword_b : mem[addr_a],
                                bus.data_a, bus.byteena_a);

    // Memory array: sweep writes zero, otherwise B then A so A wins on overlap
    always_ff @(posedge clock0) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else begin
            if (we_b) begin
                mem[addr_b] <= wword_b;
            end
            if (we_a) begin
                mem[addr_a] <= wword_a;
            end
        end
    end

    // Address latches and first read stage; reads see the pre-write word
    always_ff @(posedge clock0) begin
        if (sclr) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            q_core_a <= '0;
            q_core_b <= '0;
        end else if (clocken0) begin
            addr_a_q <= addr_a;
            addr_b_q <= addr_b;
            if (busy) begin
                q_core_a <= '0;
                q_core_b <= '0;
            end else begin
                if (bus.rden_a) begin
                    q_core_a <= (NEW_DATA_MODE && bus.wren_a) ? own_new_a : mem[addr_a];
                end
                if (bus.rden_b) begin
                    q_core_b <= (NEW_DATA_MODE && bus.wren_b) ? own_new_b : mem[addr_b];
                end
            end
        end
    end

    // Collision flag: one-cycle pulse after a same-address dual write
    always_ff @(posedge clock0) begin
        if (sclr || !clocken0) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= same_addr_write;
        end
    end

    generate
        if (OUTDATA_REG) begin : g_outreg
            logic [WIDTH-1:0] q_out_a;
            logic [WIDTH-1:0] q_out_b;

            // Optional second stage adds one cycle of read latency
            always_ff @(posedge clock0) begin
                if (sclr) begin
                    q_out_a <= '0;
                    q_out_b <= '0;
                end else if (clocken0) begin
                    q_out_a <= q_core_a;
                    q_out_b <= q_core_b;
                end
            end

            assign q_pipe_a = q_out_a;
            assign q_pipe_b = q_out_b;
        end else begin : g_no_outreg
            assign q_pipe_a = q_core_a;
            assign q_pipe_b = q_core_b;
        end
    endgenerate

    assign bus.q_a       = (sclr || busy) ? '0 : q_pipe_a;
    assign bus.q_b       = (sclr || busy) ? '0 : q_pipe_b;
    assign bus.init_busy = busy;
    assign bus.collision = collision_q && !sclr;

endmodule
`default_nettype wire

// File: tb/tb_syncram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_syncram_dp
//  Description : Self-checking bench for syncram_dp. Two instances share one
//                stimulus: OLD_DATA without output register, NEW_DATA with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_syncram_dp;

    logic        clk;
    logic        sclr;
    logic        en;
    logic        wren_a, wren_b, rden_a, rden_b;
    logic [3:0]  address_a, address_b;
    logic        stall_a, stall_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  be_a, be_b;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit done = 0;

    syncram_dp_if #(.WIDTH(32), .WIDTHAD(4), .BYTE_SIZE(8)) bus0 ();
    syncram_dp_if #(.WIDTH(32), .WIDTHAD(4), .BYTE_SIZE(8)) bus1 ();

    assign bus0.wren_a = wren_a;          assign bus1.wren_a = wren_a;
    assign bus0.wren_b = wren_b;          assign bus1.wren_b = wren_b;
    assign bus0.rden_a = rden_a;          assign bus1.rden_a = rden_a;
    assign bus0.rden_b = rden_b;          assign bus1.rden_b = rden_b;
    assign bus0.address_a = address_a;    assign bus1.address_a = address_a;
    assign bus0.address_b = address_b;    assign bus1.address_b = address_b;
    assign bus0.addressstall_a = stall_a; assign bus1.addressstall_a = stall_a;
    assign bus0.addressstall_b = stall_b; assign bus1.addressstall_b = stall_b;
    assign bus0.data_a = data_a;          assign bus1.data_a = data_a;
    assign bus0.data_b = data_b;          assign bus1.data_b = data_b;
    assign bus0.byteena_a = be_a;         assign bus1.byteena_a = be_a;
    assign bus0.byteena_b = be_b;         assign bus1.byteena_b = be_b;

    syncram_dp #(
        .WIDTH(32), .WIDTHAD(4), .BYTE_SIZE(8), .OUTDATA_REG(1'b0),
        .RDW_MODE("OLD_DATA"), .CLEAR_ON_RESET(1'b1)
    ) dut_old (
        .clock0(clk), .sclr(sclr), .clocken0(en), .bus(bus0.slave)
    );

    syncram_dp #(
        .WIDTH(32), .WIDTHAD(4), .BYTE_SIZE(8), .OUTDATA_REG(1'b1),
        .RDW_MODE("NEW_DATA"), .CLEAR_ON_RESET(1'b1)
    ) dut_new (
        .clock0(clk), .sclr(sclr), .clocken0(en), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_mem [16];
    bit          m_busy = 0;
    int          m_sweep = 0;
    logic [3:0]  m_lat_a = '0, m_lat_b = '0;
    logic [31:0] m_qo_a = '0, m_qo_b = '0;   // OLD_DATA instance, 1-cycle latency
    logic [31:0] m_qn_a = '0, m_qn_b = '0;   // NEW_DATA instance, first stage
    logic [31:0] m_qr_a = '0, m_qr_b = '0;   // NEW_DATA instance, visible output
    bit          m_coll = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [3:0]  ea, eb;
        logic [31:0] old_a, old_b;
        ea = stall_a ? m_lat_a : address_a;
        eb = stall_b ? m_lat_b : address_b;
        if (sclr) begin
            started = 1;
            m_busy = 1; m_sweep = 0;
            m_lat_a = '0; m_lat_b = '0;
            m_qo_a = '0; m_qo_b = '0; m_qn_a = '0; m_qn_b = '0; m_qr_a = '0; m_qr_b = '0;
            m_coll = 0;
        end else if (!en) begin
            m_coll = 0;
        end else if (m_busy) begin
            m_mem[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == 16) begin
                m_busy = 0;
                m_sweep = 0;
            end
            m_lat_a = ea; m_lat_b = eb;
            m_qo_a = '0; m_qo_b = '0; m_qn_a = '0; m_qn_b = '0; m_qr_a = '0; m_qr_b = '0;
            m_coll = 0;
        end else begin
            m_lat_a = ea; m_lat_b = eb;
            old_a = m_mem[ea];
            old_b = m_mem[eb];
            m_qr_a = m_qn_a;
            m_qr_b = m_qn_b;
            if (rden_a) begin
                m_qo_a = old_a;
                m_qn_a = wren_a ? merge(old_a, data_a, be_a) : old_a;
            end
            if (rden_b) begin
                m_qo_b = old_b;
                m_qn_b = wren_b ? merge(old_b, data_b, be_b) : old_b;
            end
            if (wren_b) m_mem[eb] = merge(old_b, data_b, be_b);
            if (wren_a) m_mem[ea] = merge(m_mem[ea], data_a, be_a);
            m_coll = wren_a && wren_b && (ea == eb);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started && !done) begin
            check("busy_old", 32'(bus0.init_busy), 32'(sclr ? 1'b1 : m_busy));
            check("busy_new", 32'(bus1.init_busy), 32'(sclr ? 1'b1 : m_busy));
            check("coll_old", 32'(bus0.collision), 32'(sclr ? 1'b0 : m_coll));
            check("coll_new", 32'(bus1.collision), 32'(sclr ? 1'b0 : m_coll));
            check("q_a_old", bus0.q_a, (sclr || m_busy) ? 32'h0 : m_qo_a);
            check("q_b_old", bus0.q_b, (sclr || m_busy) ? 32'h0 : m_qo_b);
            check("q_a_new", bus1.q_a, (sclr || m_busy) ? 32'h0 : m_qr_a);
            check("q_b_new", bus1.q_b, (sclr || m_busy) ? 32'h0 : m_qr_b);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        bit wa; logic [3:0] aa; logic [31:0] da; logic [3:0] ba; bit ra;
        bit wb; logic [3:0] ab; logic [31:0] db; logic [3:0] bb; bit rb;
    } vec_t;

    vec_t vecs [8] = '{
        '{1, 4'd10, 32'h01020304, 4'hF, 1, 1, 4'd11, 32'hA0B0C0D0, 4'hF, 1},
        '{0, 4'd11, 32'h0,        4'hF, 1, 0, 4'd10, 32'h0,        4'hF, 1},
        '{1, 4'd10, 32'hFFFFFFFF, 4'h0, 1, 1, 4'd10, 32'h55555555, 4'h3, 1},
        '{0, 4'd10, 32'h0,        4'hF, 1, 0, 4'd11, 32'h0,        4'hF, 1},
        '{1, 4'd12, 32'h12345678, 4'h9, 1, 1, 4'd12, 32'h9ABCDEF0, 4'h6, 1},
        '{0, 4'd12, 32'h0,        4'hF, 1, 1, 4'd12, 32'h0,        4'h8, 1},
        '{0, 4'd12, 32'h0,        4'hF, 1, 0, 4'd0,  32'h0,        4'hF, 1},
        '{0, 4'd10, 32'h0,        4'hF, 1, 0, 4'd0,  32'h0,        4'hF, 0}
    };

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
        stall_a = 0; stall_b = 0; be_a = 4'hF; be_b = 4'hF;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 60 && bus0.init_busy; i++) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int busy_cycles;
        sclr = 1; en = 1; idle();
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;

        // Reset then full sweep of 16 words
        tick();
        sclr = 0;
        count_busy(busy_cycles);
        check("sweep_len", 32'(busy_cycles), 32'd16);
        check("busy_done", 32'(bus0.init_busy), 32'd0);

        // Every address reads zero after the sweep
        for (int a = 0; a < 16; a++) begin
            rden_a = 1; address_a = 4'(a);
            rden_b = 1; address_b = 4'(15 - a);
            tick();
            check("zero_fill", bus0.q_a, 32'h0);
        end

        // Byte-enabled partial write
        idle(); wren_a = 1; address_a = 4'd3; data_a = 32'hAABBCCDD; tick();
        data_a = 32'h11223344; be_a = 4'b0101; tick();
        idle(); rden_a = 1; address_a = 4'd3; tick();
        check("byteena_old", bus0.q_a, 32'hAA22CC44);
        check("model_addr3", m_mem[3], 32'hAA22CC44);
        rden_a = 0; tick();
        check("byteena_new", bus1.q_a, 32'hAA22CC44);

        // Read-during-write, same port and cross port
        idle(); wren_a = 1; address_a = 4'd5; data_a = 32'h1; tick();
        data_a = 32'h2; rden_a = 1; rden_b = 1; address_b = 4'd5; tick();
        check("rdw_same_old", bus0.q_a, 32'h1);
        check("rdw_cross_old", bus0.q_b, 32'h1);
        idle(); tick();
        check("rdw_same_new", bus1.q_a, 32'h2);
        check("rdw_cross_new", bus1.q_b, 32'h1);

        // Same-address dual write
        idle(); wren_a = 1; address_a = 4'd7; data_a = 32'hFFFF0000; be_a = 4'b1100;
        wren_b = 1; address_b = 4'd7; data_b = 32'h0000FFFF; be_b = 4'b1111; tick();
        check("collision_hi", 32'(bus0.collision), 32'd1);
        idle(); rden_a = 1; address_a = 4'd7; tick();
        check("collision_lo", 32'(bus0.collision), 32'd0);
        check("collision_word", bus0.q_a, 32'hFFFFFFFF);

        // Address stall on read
        idle(); wren_a = 1; address_a = 4'd2; data_a = 32'h22222222; tick();
        address_a = 4'd9; data_a = 32'h99999999; tick();
        idle(); rden_a = 1; address_a = 4'd2; tick();
        stall_a = 1; address_a = 4'd9; tick(3);
        check("stall_old", bus0.q_a, 32'h22222222);
        check("stall_new", bus1.q_a, 32'h22222222);
        stall_a = 0; tick();
        check("unstall", bus0.q_a, 32'h99999999);
        rden_a = 0; address_a = 4'd3; tick(2);
        check("rden_hold", bus0.q_a, 32'h99999999);

        // Address stall on write
        idle(); rden_b = 1; address_b = 4'd4; tick();
        rden_b = 0; stall_b = 1; address_b = 4'd10; wren_b = 1; data_b = 32'h00004444; tick();
        idle(); rden_a = 1; address_a = 4'd4; tick();
        check("stall_write", bus0.q_a, 32'h00004444);

        // Directed mixed-port vectors, checked by the model
        for (int i = 0; i < 8; i++) begin
            idle();
            wren_a = vecs[i].wa; address_a = vecs[i].aa; data_a = vecs[i].da; be_a = vecs[i].ba; rden_a = vecs[i].ra;
            wren_b = vecs[i].wb; address_b = vecs[i].ab; data_b = vecs[i].db; be_b = vecs[i].bb; rden_b = vecs[i].rb;
            tick();
        end
        check("model_addr10", m_mem[10], 32'h01025555);
        check("model_addr12", m_mem[12], 32'h00BCDE78);

        // Clock enable low freezes writes and outputs
        idle(); en = 0; wren_a = 1; address_a = 4'd1; data_a = 32'hDEADBEEF; rden_b = 1; address_b = 4'd7; tick(2);
        idle(); en = 1; rden_a = 1; address_a = 4'd1; tick();
        check("frozen_write", bus0.q_a, 32'h0);

        // Clock enable low mid-sweep holds the sweep
        idle(); sclr = 1; tick(); sclr = 0; tick(4);
        en = 0; tick(5);
        check("sweep_frozen", 32'(bus0.init_busy), 32'd1);
        en = 1;
        count_busy(busy_cycles);
        check("sweep_resume", 32'(busy_cycles), 32'd12);

        // Reset mid-sweep restarts from address 0
        sclr = 1; tick(); sclr = 0; tick(3);
        sclr = 1; tick(); sclr = 0;
        count_busy(busy_cycles);
        check("sweep_restart", 32'(busy_cycles), 32'd16);
        rden_a = 1; address_a = 4'd3; rden_b = 1; address_b = 4'd7; tick();
        check("recleared_a", bus0.q_a, 32'h0);
        check("recleared_b", bus0.q_b, 32'h0);
        idle(); tick(2);

        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
